// File: rtl/vend_pkg.sv
// Shared types, encodings and default parameters for the vending controller.
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CREDIT   = 2'd1,
      S_DISPENSE = 2'd2,
      S_CHANGE   = 2'd3
   } state_e;

   // Same encoding serves the coin input and the change output.
   typedef enum logic [1:0] {
      NONE    = 2'b00,
      ONE     = 2'b01,
      TWO     = 2'b10,
      INVALID = 2'b11
   } coin_e;

   localparam int PRICE_DEF       = 3;
   localparam int MAX_CREDIT_DEF  = 15;
   localparam int STOCK_INIT_DEF  = 8;
   localparam int DISP_CYCLES_DEF = 4;

   localparam int NUM_PROD = 4;
   localparam int CREDIT_W = 4;
   localparam int STOCK_W  = 4;

   function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] c);
      case (c)
         ONE:     coin_value = (CREDIT_W+1)'(1);
         TWO:     coin_value = (CREDIT_W+1)'(2);
         default: coin_value = '0;
      endcase
   endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-product stock counters with saturating decrement, bulk refill and a
// registered sold-out vector that tracks the counts cycle for cycle.
module vend_stock_bank
   import vend_pkg::*;
#(
   parameter int STOCK_INIT = STOCK_INIT_DEF
)(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               dec_en,
   input  logic [1:0]                         dec_id,
   input  logic                               refill,
   output logic [NUM_PROD-1:0][STOCK_W-1:0]   stock,
   output logic [NUM_PROD-1:0]                sold_out
);

   localparam logic [STOCK_W-1:0] INIT_V = STOCK_W'(STOCK_INIT);
   localparam logic [STOCK_W-1:0] ONE_V  = STOCK_W'(1);

   logic [NUM_PROD-1:0][STOCK_W-1:0] stock_q, stock_d;
   logic [NUM_PROD-1:0]              sold_out_q, sold_out_d;

   always_comb begin
      stock_d    = stock_q;
      sold_out_d = sold_out_q;
      for (int i = 0; i < NUM_PROD; i++) begin
         if (refill)
            stock_d[i] = INIT_V;
         else if (dec_en && dec_id == 2'(i) && stock_q[i] != '0)
            stock_d[i] = stock_q[i] - ONE_V;
         sold_out_d[i] = (stock_d[i] == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stock_q    <= {NUM_PROD{INIT_V}};
         sold_out_q <= {NUM_PROD{INIT_V == '0}};
      end else begin
         stock_q    <= stock_d;
         sold_out_q <= sold_out_d;
      end
   end

   assign stock    = stock_q;
   assign sold_out = sold_out_q;

endmodule

// File: rtl/vend_controller.sv
// Coin-operated vending controller: credit accumulation, product dispense
// pulse, change payout and per-product stock tracking.
module vend_controller
   import vend_pkg::*;
#(
   parameter int PRICE       = PRICE_DEF,
   parameter int MAX_CREDIT  = MAX_CREDIT_DEF,
   parameter int STOCK_INIT  = STOCK_INIT_DEF,
   parameter int DISP_CYCLES = DISP_CYCLES_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            in,
   input  logic                  sel_valid,
   input  logic [1:0]            sel_id,
   input  logic                  cancel,
   input  logic                  refill,
   output logic [CREDIT_W-1:0]   credit,
   output logic                  out,
   output logic [1:0]            disp_id,
   output logic [1:0]            change,
   output logic                  reject,
   output logic                  busy,
   output logic [NUM_PROD-1:0]   sold_out
);

   localparam int CNT_W = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    DISP_LAST = CNT_W'(DISP_CYCLES - 1);
   localparam logic [CREDIT_W:0]   PRICE_V   = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0]   MAX_V     = (CREDIT_W+1)'(MAX_CREDIT);

   state_e                            state_q, state_d;
   logic [CREDIT_W-1:0]               credit_q, credit_d;
   logic                              out_q, out_d;
   logic [1:0]                        disp_id_q, disp_id_d;
   logic [1:0]                        change_q, change_d;
   logic                              reject_q, reject_d;
   logic                              busy_q, busy_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [CREDIT_W:0]                 acc;
   logic                              dec_en, refill_en;
   logic [NUM_PROD-1:0][STOCK_W-1:0]  stock;

   vend_stock_bank #(.STOCK_INIT(STOCK_INIT)) u_stock (
      .clk      (clk),
      .rst      (rst),
      .dec_en   (dec_en),
      .dec_id   (sel_id),
      .refill   (refill_en),
      .stock    (stock),
      .sold_out (sold_out)
   );

   always_comb begin
      state_d   = state_q;
      credit_d  = credit_q;
      out_d     = 1'b0;
      disp_id_d = disp_id_q;
      change_d  = NONE;
      reject_d  = 1'b0;
      cnt_d     = cnt_q;
      dec_en    = 1'b0;
      refill_en = 1'b0;
      acc       = {1'b0, credit_q};
      unique case (state_q)
         S_IDLE, S_CREDIT: begin
            // Cancel beats selection; selection sees credit before this cycle's coin.
            if (state_q == S_CREDIT && cancel) begin
               state_d = S_CHANGE;
            end else if (state_q == S_CREDIT && sel_valid && acc >= PRICE_V &&
                         stock[sel_id] != '0) begin
               state_d   = S_DISPENSE;
               acc       = acc - PRICE_V;
               dec_en    = 1'b1;
               out_d     = 1'b1;
               disp_id_d = sel_id;
               cnt_d     = DISP_LAST;
            end
            refill_en = (state_q == S_IDLE) && refill;
            if (in == INVALID) begin
               reject_d = 1'b1;
            end else if (in != NONE) begin
               if (acc + coin_value(in) > MAX_V) reject_d = 1'b1;
               else                              acc = acc + coin_value(in);
            end
            credit_d = acc[CREDIT_W-1:0];
            if (state_q == S_IDLE && acc != '0) state_d = S_CREDIT;
         end
         S_DISPENSE: begin
            reject_d = (in != NONE);
            if (cnt_q == '0) begin
               state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               out_d = 1'b1;
            end
         end
         S_CHANGE: begin
            reject_d = (in != NONE);
            if (credit_q >= CREDIT_W'(2)) begin
               change_d = TWO;
               credit_d = credit_q - CREDIT_W'(2);
            end else if (credit_q != '0) begin
               change_d = ONE;
               credit_d = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_DISPENSE) || (state_d == S_CHANGE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         credit_q  <= '0;
         out_q     <= 1'b0;
         disp_id_q <= '0;
         change_q  <= NONE;
         reject_q  <= 1'b0;
         busy_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         credit_q  <= credit_d;
         out_q     <= out_d;
         disp_id_q <= disp_id_d;
         change_q  <= change_d;
         reject_q  <= reject_d;
         busy_q    <= busy_d;
         cnt_q     <= cnt_d;
      end
   end

   assign credit  = credit_q;
   assign out     = out_q;
   assign disp_id = disp_id_q;
   assign change  = change_q;
   assign reject  = reject_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: a vector table of single-cycle
// stimulus/response pairs plus hand sequences for stock, refill and reset.
module tb_vend_controller;

   logic       clk, rst;
   logic [1:0] in_i, sel_id;
   logic       sel_valid, cancel, refill;
   logic [3:0] credit;
   logic       out;
   logic [1:0] disp_id, change;
   logic       reject, busy;
   logic [3:0] sold_out;

   int checks = 0;
   int errors = 0;
   int stock_m[4];

   vend_controller dut (
      .clk       (clk),
      .rst       (rst),
      .in        (in_i),
      .sel_valid (sel_valid),
      .sel_id    (sel_id),
      .cancel    (cancel),
      .refill    (refill),
      .credit    (credit),
      .out       (out),
      .disp_id   (disp_id),
      .change    (change),
      .reject    (reject),
      .busy      (busy),
      .sold_out  (sold_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] in;
      logic       sel;
      logic [1:0] id;
      logic       can;
      logic [3:0] cr;
      logic       o;
      logic [1:0] d;
      logic [1:0] ch;
      logic       rj;
      logic       b;
   } vec_t;

   vec_t vt[$];

   task automatic v(input logic [1:0] i, input logic s, input logic [1:0] id,
                    input logic c, input logic [3:0] cr, input logic o,
                    input logic [1:0] d, input logic [1:0] ch, input logic rj,
                    input logic b);
      vec_t r;
      r.in = i; r.sel = s; r.id = id; r.can = c; r.cr = cr;
      r.o = o; r.d = d; r.ch = ch; r.rj = rj; r.b = b;
      vt.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [1:0] i, input logic s, input logic [1:0] id,
                       input logic c, input logic r);
      in_i = i; sel_valid = s; sel_id = id; cancel = c; refill = r;
      @(posedge clk); #1;
      in_i = 2'b00; sel_valid = 1'b0; sel_id = 2'd0; cancel = 1'b0; refill = 1'b0;
   endtask

   function automatic logic [3:0] so_m();
      logic [3:0] s;
      for (int k = 0; k < 4; k++) s[k] = (stock_m[k] == 0);
      return s;
   endfunction

   function automatic logic [14:0] pack_out();
      return {credit, out, disp_id, change, reject, busy, sold_out};
   endfunction

   // Insert exactly the price (2+1), buy, and ride out the dispense pulse.
   task automatic buy(input logic [1:0] id);
      step(2'b10, 0, 0, 0, 0);
      step(2'b01, 0, 0, 0, 0);
      step(2'b00, 1, id, 0, 0);
      if (stock_m[id] > 0) stock_m[id]--;
      chk($sformatf("buy%0d_out", id), {out, disp_id}, {1'b1, id});
      chk($sformatf("buy%0d_soldout", id), sold_out, so_m());
      repeat (4) step(2'b00, 0, 0, 0, 0);
      chk($sformatf("buy%0d_idle", id), {credit, out, busy}, 6'd0);
   endtask

   initial begin
      logic [14:0] act, exp;
      rst = 1'b1; in_i = 0; sel_valid = 0; sel_id = 0; cancel = 0; refill = 0;
      for (int k = 0; k < 4; k++) stock_m[k] = 8;

      // in, sel, id, cancel | credit, out, disp_id, change, reject, busy
      // three single coins, buy id 2
      v(2'b01,0,0,0,  1,0,0,0,0,0);
      v(2'b01,0,0,0,  2,0,0,0,0,0);
      v(2'b01,0,0,0,  3,0,0,0,0,0);
      v(2'b00,1,2,0,  0,1,2,0,0,1);
      v(2'b00,0,0,0,  0,1,2,0,0,1);
      v(2'b00,0,0,0,  0,1,2,0,0,1);
      v(2'b00,0,0,0,  0,1,2,0,0,1);
      v(2'b00,0,0,0,  0,0,0,0,0,0);
      // three double coins, buy id 0, coins during dispense/change rejected
      v(2'b10,0,0,0,  2,0,0,0,0,0);
      v(2'b10,0,0,0,  4,0,0,0,0,0);
      v(2'b10,0,0,0,  6,0,0,0,0,0);
      v(2'b00,1,0,0,  3,1,0,0,0,1);
      v(2'b10,0,0,0,  3,1,0,0,1,1);
      v(2'b00,0,0,0,  3,1,0,0,0,1);
      v(2'b00,0,0,0,  3,1,0,0,0,1);
      v(2'b00,0,0,0,  3,0,0,0,0,1);
      v(2'b01,0,0,0,  1,0,0,2,1,1);
      v(2'b00,0,0,0,  0,0,0,1,0,1);
      v(2'b00,0,0,0,  0,0,0,0,0,0);
      // fill to 14, overflow reject, exact ceiling 15, cancel full payout
      v(2'b10,0,0,0,  2,0,0,0,0,0);
      v(2'b10,0,0,0,  4,0,0,0,0,0);
      v(2'b10,0,0,0,  6,0,0,0,0,0);
      v(2'b10,0,0,0,  8,0,0,0,0,0);
      v(2'b10,0,0,0, 10,0,0,0,0,0);
      v(2'b10,0,0,0, 12,0,0,0,0,0);
      v(2'b10,0,0,0, 14,0,0,0,0,0);
      v(2'b10,0,0,0, 14,0,0,0,1,0);
      v(2'b01,0,0,0, 15,0,0,0,0,0);
      v(2'b01,0,0,0, 15,0,0,0,1,0);
      v(2'b00,0,0,1, 15,0,0,0,0,1);
      v(2'b00,0,0,0, 13,0,0,2,0,1);
      v(2'b00,0,0,0, 11,0,0,2,0,1);
      v(2'b00,0,0,0,  9,0,0,2,0,1);
      v(2'b00,0,0,0,  7,0,0,2,0,1);
      v(2'b00,0,0,0,  5,0,0,2,0,1);
      v(2'b00,0,0,0,  3,0,0,2,0,1);
      v(2'b00,0,0,0,  1,0,0,2,0,1);
      v(2'b00,0,0,0,  0,0,0,1,0,1);
      v(2'b00,0,0,0,  0,0,0,0,0,0);
      v(2'b11,0,0,0,  0,0,0,0,1,0);
      v(2'b00,0,0,1,  0,0,0,0,0,0);
      // credit 5, select+cancel together: cancel wins
      v(2'b10,0,0,0,  2,0,0,0,0,0);
      v(2'b10,0,0,0,  4,0,0,0,0,0);
      v(2'b01,0,0,0,  5,0,0,0,0,0);
      v(2'b00,1,3,1,  5,0,0,0,0,1);
      v(2'b00,0,0,0,  3,0,0,2,0,1);
      v(2'b10,0,0,0,  1,0,0,2,1,1);
      v(2'b00,0,0,0,  0,0,0,1,0,1);
      v(2'b00,0,0,0,  0,0,0,0,0,0);
      // selection judged on credit before the same-cycle coin
      v(2'b10,0,0,0,  2,0,0,0,0,0);
      v(2'b01,1,0,0,  3,0,0,0,0,0);
      v(2'b10,1,0,0,  2,1,0,0,0,1);
      v(2'b00,0,0,0,  2,1,0,0,0,1);
      v(2'b00,0,0,0,  2,1,0,0,0,1);
      v(2'b00,0,0,0,  2,1,0,0,0,1);
      v(2'b00,0,0,0,  2,0,0,0,0,1);
      v(2'b00,0,0,0,  0,0,0,2,0,1);
      v(2'b00,0,0,0,  0,0,0,0,0,0);

      repeat (2) @(posedge clk);
      #1 chk("reset_state", pack_out(), 15'd0);
      @(negedge clk) rst = 1'b0;

      foreach (vt[n]) begin
         step(vt[n].in, vt[n].sel, vt[n].id, vt[n].can, 1'b0);
         act = {credit, out, out ? disp_id : 2'b00, change, reject, busy, sold_out};
         exp = {vt[n].cr, vt[n].o, vt[n].d, vt[n].ch, vt[n].rj, vt[n].b, 4'b0000};
         chk($sformatf("vec%0d", n), act, exp);
      end
      stock_m[2] = 7; stock_m[0] = 6;

      // exhaust product 1, then a ninth selection is ignored
      repeat (8) buy(2'd1);
      step(2'b01, 0, 0, 0, 0);
      step(2'b01, 0, 0, 0, 0);
      step(2'b01, 0, 0, 0, 0);
      step(2'b00, 1, 1, 0, 0);
      chk("soldout_sel_ignored", {credit, out, busy}, {4'd3, 1'b0, 1'b0});
      step(2'b00, 0, 0, 0, 1);
      chk("refill_in_credit", sold_out, 4'b0010);
      step(2'b00, 0, 0, 1, 0);
      chk("cancel_enter", {credit, busy, change}, {4'd3, 1'b1, 2'b00});
      step(2'b00, 0, 0, 0, 0);
      chk("cancel_chg2", {credit, change}, {4'd1, 2'b10});
      step(2'b00, 0, 0, 0, 0);
      chk("cancel_chg1", {credit, change}, {4'd0, 2'b01});
      step(2'b00, 0, 0, 0, 0);
      chk("cancel_idle", {credit, busy, change}, 7'd0);

      // asynchronous reset during the second dispense cycle
      step(2'b10, 0, 0, 0, 0);
      step(2'b10, 0, 0, 0, 0);
      step(2'b01, 0, 0, 0, 0);
      step(2'b00, 1, 0, 0, 0);
      chk("rst_pre_out", {credit, out}, {4'd2, 1'b1});
      step(2'b00, 0, 0, 0, 0);
      #2 rst = 1'b1;
      #1 chk("rst_async", pack_out(), 15'd0);
      for (int k = 0; k < 4; k++) stock_m[k] = 8;
      @(negedge clk) rst = 1'b0;
      step(2'b01, 0, 0, 0, 0);
      chk("post_rst_coin", {credit, busy, change}, {4'd1, 1'b0, 2'b00});
      step(2'b00, 0, 0, 1, 0);
      step(2'b00, 0, 0, 0, 0);
      chk("post_rst_chg", {credit, change}, {4'd0, 2'b01});
      step(2'b00, 0, 0, 0, 0);

      // stock restored to full by reset, then refill in idle
      repeat (8) buy(2'd2);
      step(2'b00, 0, 0, 0, 1);
      for (int k = 0; k < 4; k++) stock_m[k] = 8;
      chk("refill_idle", sold_out, so_m());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter PRICE, default 3, product price in coin units (1 unit = one "01" coin).
REQ-002 SHALL have parameter MAX_CREDIT, default 15, credit ceiling in units, fits credit width.
REQ-003 SHALL have parameter STOCK_INIT, default 8, per-product stock loaded on reset or refill, max 15.
REQ-004 SHALL have parameter DISP_CYCLES, default 4, dispense pulse length in cycles, minimum 1.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port in  input  2  coin: 00 none, 01 one unit, 10 two units, 11 invalid.
REQ-008 SHALL have port sel_valid  input  1  product selection strobe.
REQ-009 SHALL have port sel_id  input  2  product index 0-3, sampled with sel_valid.
REQ-010 SHALL have port cancel  input  1  abort request and return all credit.
REQ-011 SHALL have port refill  input  1  restock all products to STOCK_INIT.
REQ-012 SHALL have port credit  output  4  current credit in units.
REQ-013 SHALL have port out  output  1  dispense motor enable.
REQ-014 SHALL have port disp_id  output  2  product being dispensed, valid while out=1.
REQ-015 SHALL have port change  output  2  change coin per cycle: 00 none, 01 one unit, 10 two units.
REQ-016 SHALL have port reject  output  1  one-cycle pulse: the coin presented in the previous cycle was returned.
REQ-017 SHALL have port busy  output  1  high in DISPENSE or CHANGE.
REQ-018 SHALL have port sold_out  output  4  bit i high when stock[i]==0.

Function
REQ-019 SHALL implement states IDLE, CREDIT, DISPENSE, CHANGE; all outputs registered.
REQ-020 IDLE/CREDIT: valid coin adds its value to credit next cycle; IDLE->CREDIT when credit becomes nonzero.
REQ-021 Coin is rejected (reject=1 next cycle, credit unchanged) if in==11, if credit+value>MAX_CREDIT, or if the state is DISPENSE/CHANGE.
REQ-022 CREDIT, sel_valid, credit>=PRICE, stock[sel_id]>0: next cycle state=DISPENSE, credit-=PRICE, stock[sel_id]-=1, out=1, disp_id=sel_id.
REQ-023 Selection with insufficient credit or sold-out product SHALL be ignored; state and credit unchanged.
REQ-024 Selection SHALL be evaluated against credit before a same-cycle coin; that coin is still accepted per REQ-020/021.
REQ-025 DISPENSE holds out=1 for exactly DISP_CYCLES cycles, then enters CHANGE if credit>0, else IDLE.
REQ-026 CHANGE: each cycle pays change=10 (credit-=2) while credit>=2, else change=01 (credit-=1); enters IDLE the cycle after credit reaches 0.
REQ-027 cancel in CREDIT enters CHANGE next cycle; cancel in IDLE, DISPENSE or CHANGE SHALL be ignored.
REQ-028 cancel and sel_valid in the same cycle: cancel wins, no dispense.
REQ-029 refill SHALL be honoured only in IDLE (all stock = STOCK_INIT next cycle); otherwise ignored.
REQ-030 Stock counters SHALL never wrap below 0; credit SHALL never exceed MAX_CREDIT or go below 0.
REQ-031 sold_out SHALL reflect updated stock one cycle after a decrement or refill.

Reset
REQ-032 rst SHALL immediately force state=IDLE, credit=0, out=0, disp_id=0, change=00, reject=0, busy=0, stock[all]=STOCK_INIT, sold_out=0.
REQ-033 rst asserted mid-DISPENSE or mid-CHANGE SHALL abandon the operation; outstanding credit is lost, no further change is paid.

Structure
REQ-034 Package vend_pkg SHALL hold the state enumeration, coin/change encodings (NONE, ONE, TWO, INVALID) and default parameter values.
REQ-035 Per-product stock counters SHALL be a sub-module vend_stock_bank (decrement port, refill port, 4x4-bit counts, sold_out vector).

Verification
REQ-036 Coins 01,01,01 then sel_valid id=2 -> credit 3, out=1 for 4 cycles with disp_id=2, credit 0, return to IDLE, stock[2]=7.
REQ-037 Coins 10,10,10 (credit 6), sel id=0 -> dispense, then change=10 one cycle, change=01 one cycle, IDLE, credit 0.
REQ-038 Credit 14 plus coin 10 -> reject=1, credit stays 14; coin 11 in IDLE -> reject=1, credit 0.
REQ-039 Eight purchases of id=1 -> sold_out[1]=1; ninth selection with credit 3 ignored, credit stays 3; cancel -> change=10, change=01, IDLE.
REQ-040 Credit 5, sel_valid and cancel same cycle -> no out pulse, change 10,10,01; coin during CHANGE -> reject=1.
REQ-041 rst asserted on 2nd DISPENSE cycle -> out=0 immediately, credit=0, stock[all]=8, state IDLE; refill during CREDIT ignored.
